// File: rtl/nbin_buf_pkg.sv
// rtl/nbin_buf_pkg.sv - shared types and constants for the NBin ping-pong buffer
package nbin_buf_pkg;

  localparam int NUM_BANKS = 2;

  typedef enum logic {
    BANK_EMPTY = 1'b0,
    BANK_FULL  = 1'b1
  } bank_state_e;

  // One stored entry is the NBin word concatenated with its offset word.
  function automatic int entry_w(input int n, input int tn, input int offset_sz);
    return tn * (n + offset_sz);
  endfunction

endpackage

// File: rtl/nbin_buf_bank.sv
// rtl/nbin_buf_bank.sv - one 1W1R entry array with registered read port
module nbin_buf_bank #(
  parameter int NUM_WORDS = 64,
  parameter int ADDR_SZ   = 6,
  parameter int WIDTH     = 320
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [ADDR_SZ-1:0] wr_addr,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic               rd_en,
  input  logic [ADDR_SZ-1:0] rd_addr,
  output logic [WIDTH-1:0]   rd_data
);

  logic [WIDTH-1:0] mem [NUM_WORDS];

  // Contents are deliberately not reset; the read register holds between reads.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/nbin_pingpong_buf.sv
// rtl/nbin_pingpong_buf.sv - double-buffered NBin/offset buffer between loader and NFU
module nbin_pingpong_buf
  import nbin_buf_pkg::*;
#(
  parameter int N         = 16,
  parameter int Tn        = 16,
  parameter int OFFSET_SZ = 4,
  parameter int NUM_WORDS = 64,
  parameter int ADDR_SZ   = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_wr_valid,
  output logic                    o_wr_ready,
  input  logic [Tn*N-1:0]         i_wr_nbin,
  input  logic [Tn*OFFSET_SZ-1:0] i_wr_offset,
  input  logic                    i_wr_last,
  output logic                    o_wr_bank,
  output logic                    o_rd_avail,
  output logic                    o_rd_bank,
  output logic [ADDR_SZ:0]        o_rd_count,
  input  logic                    i_rd_en,
  input  logic [ADDR_SZ-1:0]      i_rd_addr,
  output logic                    o_rd_valid,
  output logic [Tn*N-1:0]         o_rd_nbin,
  output logic [Tn*OFFSET_SZ-1:0] o_rd_offset,
  input  logic                    i_rd_release
);

  localparam int ENTRY_W = entry_w(N, Tn, OFFSET_SZ);
  localparam int CNT_W   = ADDR_SZ + 1;

  bank_state_e        state_q [NUM_BANKS];
  bank_state_e        state_d [NUM_BANKS];
  logic [CNT_W-1:0]   count_q [NUM_BANKS];
  logic [CNT_W-1:0]   count_d [NUM_BANKS];
  logic               wr_bank_q, wr_bank_d;
  logic               rd_bank_q, rd_bank_d;
  logic [ADDR_SZ-1:0] wr_ptr_q, wr_ptr_d;

  logic               rd_valid_q, rd_sel_q, rd_zero_q;
  logic [ENTRY_W-1:0] bank_rdata [NUM_BANKS];
  logic [ENTRY_W-1:0] sel_entry;

  logic wr_fire, fill_done, rd_fire, rel_fire;

  assign o_wr_ready = (state_q[wr_bank_q] == BANK_EMPTY);
  assign o_rd_avail = (state_q[rd_bank_q] == BANK_FULL);
  assign o_wr_bank  = wr_bank_q;
  assign o_rd_bank  = rd_bank_q;
  assign o_rd_count = o_rd_avail ? count_q[rd_bank_q] : '0;

  assign wr_fire   = i_wr_valid && o_wr_ready;
  assign fill_done = i_wr_last || (wr_ptr_q == ADDR_SZ'(NUM_WORDS - 1));
  assign rd_fire   = i_rd_en && o_rd_avail;
  assign rel_fire  = i_rd_release && o_rd_avail;

  // Fill completion and release always target different banks, so both may land together.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_ptr_d  = wr_ptr_q;
    if (wr_fire) begin
      if (fill_done) begin
        state_d[wr_bank_q] = BANK_FULL;
        count_d[wr_bank_q] = CNT_W'(wr_ptr_q) + CNT_W'(1);
        wr_bank_d          = ~wr_bank_q;
        wr_ptr_d           = '0;
      end else begin
        wr_ptr_d = wr_ptr_q + ADDR_SZ'(1);
      end
    end
    if (rel_fire) begin
      state_d[rd_bank_q] = BANK_EMPTY;
      rd_bank_d          = ~rd_bank_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        state_q[b] <= BANK_EMPTY;
        count_q[b] <= '0;
      end
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_sel_q   <= 1'b0;
      rd_zero_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_valid_q <= rd_fire;
      if (rd_fire) begin
        rd_sel_q  <= rd_bank_q;
        rd_zero_q <= ({1'b0, i_rd_addr} >= count_q[rd_bank_q]);
      end
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    nbin_buf_bank #(
      .NUM_WORDS (NUM_WORDS),
      .ADDR_SZ   (ADDR_SZ),
      .WIDTH     (ENTRY_W)
    ) u_bank (
      .clk     (clk),
      .wr_en   (wr_fire && (wr_bank_q == 1'(b))),
      .wr_addr (wr_ptr_q),
      .wr_data ({i_wr_nbin, i_wr_offset}),
      .rd_en   (rd_fire && (rd_bank_q == 1'(b))),
      .rd_addr (i_rd_addr),
      .rd_data (bank_rdata[b])
    );
  end

  // Select and zero-mask flags only move on a read, so data holds while not valid.
  assign sel_entry   = bank_rdata[rd_sel_q];
  assign o_rd_valid  = rd_valid_q;
  assign o_rd_nbin   = rd_zero_q ? '0 : sel_entry[ENTRY_W-1 -: Tn*N];
  assign o_rd_offset = rd_zero_q ? '0 : sel_entry[Tn*OFFSET_SZ-1:0];

endmodule

// File: tb/tb_nbin_pingpong_buf.sv
// tb/tb_nbin_pingpong_buf.sv - directed self-checking bench for nbin_pingpong_buf
module tb_nbin_pingpong_buf;

  localparam int N = 16, TN = 16, OFF = 4, NW = 64, AW = 6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_wr_valid, i_wr_last, i_rd_en, i_rd_release;
  logic              o_wr_ready, o_wr_bank, o_rd_avail, o_rd_bank, o_rd_valid;
  logic [TN*N-1:0]   i_wr_nbin, o_rd_nbin;
  logic [TN*OFF-1:0] i_wr_offset, o_rd_offset;
  logic [AW-1:0]     i_rd_addr;
  logic [AW:0]       o_rd_count;

  int total = 0;
  int bad   = 0;

  nbin_pingpong_buf #(.N(N), .Tn(TN), .OFFSET_SZ(OFF), .NUM_WORDS(NW), .ADDR_SZ(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready), .i_wr_nbin(i_wr_nbin),
    .i_wr_offset(i_wr_offset), .i_wr_last(i_wr_last), .o_wr_bank(o_wr_bank),
    .o_rd_avail(o_rd_avail), .o_rd_bank(o_rd_bank), .o_rd_count(o_rd_count),
    .i_rd_en(i_rd_en), .i_rd_addr(i_rd_addr), .o_rd_valid(o_rd_valid),
    .o_rd_nbin(o_rd_nbin), .o_rd_offset(o_rd_offset), .i_rd_release(i_rd_release)
  );

  always #5 clk = ~clk;

  function automatic logic [TN*N-1:0] mk_nbin(input int tag, input int idx);
    logic [15:0] w;
    w = {8'(tag), 8'(idx)};
    return {TN{w}};
  endfunction

  function automatic logic [TN*OFF-1:0] mk_off(input int tag, input int idx);
    logic [3:0] o;
    o = 4'(tag + idx);
    return {TN{o}};
  endfunction

  task automatic chk(input string tag, input logic [TN*N-1:0] obs, input logic [TN*N-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int tag, input int n, input bit with_last);
    for (int i = 0; i < n; i++) begin
      i_wr_valid  = 1'b1;
      i_wr_nbin   = mk_nbin(tag, i);
      i_wr_offset = mk_off(tag, i);
      i_wr_last   = with_last && (i == n - 1);
      step();
    end
    i_wr_valid = 1'b0;
    i_wr_last  = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input int addr, input int dtag, input bit zero);
    i_rd_en   = 1'b1;
    i_rd_addr = AW'(addr);
    step();
    i_rd_en = 1'b0;
    chk({tag, "_valid"}, o_rd_valid, 1);
    chk({tag, "_nbin"}, o_rd_nbin, zero ? '0 : mk_nbin(dtag, addr));
    chk({tag, "_off"}, o_rd_offset, zero ? '0 : mk_off(dtag, addr));
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_wr_ready"}, o_wr_ready, 1);
    chk({tag, "_wr_bank"}, o_wr_bank, 0);
    chk({tag, "_rd_avail"}, o_rd_avail, 0);
    chk({tag, "_rd_bank"}, o_rd_bank, 0);
    chk({tag, "_rd_count"}, o_rd_count, 0);
    chk({tag, "_rd_valid"}, o_rd_valid, 0);
    chk({tag, "_rd_nbin"}, o_rd_nbin, 0);
    chk({tag, "_rd_off"}, o_rd_offset, 0);
  endtask

  initial begin
    rst_n = 1'b0; i_wr_valid = 1'b0; i_wr_last = 1'b0; i_rd_en = 1'b0; i_rd_release = 1'b0;
    i_wr_nbin = '0; i_wr_offset = '0; i_rd_addr = '0;
    step(); step();
    chk_reset_outs("reset");
    rst_n = 1'b1;
    step();

    // 64-word fill with last on the final word
    fill(1, 63, 0);
    chk("pre_last_avail", o_rd_avail, 0);
    chk("pre_last_wr_bank", o_wr_bank, 0);
    i_wr_valid = 1'b1; i_wr_nbin = mk_nbin(1, 63); i_wr_offset = mk_off(1, 63); i_wr_last = 1'b1;
    step();
    i_wr_valid = 1'b0; i_wr_last = 1'b0;
    chk("f64_wr_bank", o_wr_bank, 1);
    chk("f64_avail", o_rd_avail, 1);
    chk("f64_count", o_rd_count, 64);
    chk("f64_wr_ready", o_wr_ready, 1);
    rd_chk("f64_rd0", 0, 1, 0);
    rd_chk("f64_rd63", 63, 1, 0);
    i_rd_release = 1'b1; step(); i_rd_release = 1'b0;
    chk("rel0_rd_bank", o_rd_bank, 1);
    chk("rel0_avail", o_rd_avail, 0);
    chk("rel0_count", o_rd_count, 0);

    // short fill, reads with latency and out-of-range address
    fill(2, 10, 1);
    chk("f10_wr_bank", o_wr_bank, 0);
    chk("f10_count", o_rd_count, 10);
    for (int a = 0; a < 10; a++) rd_chk($sformatf("f10_rd%0d", a), a, 2, 0);
    rd_chk("f10_rd12", 12, 2, 1);
    step();
    chk("idle_valid", o_rd_valid, 0);
    chk("idle_hold", o_rd_nbin, 0);
    i_rd_release = 1'b1; step(); i_rd_release = 1'b0;
    chk("rel1_rd_bank", o_rd_bank, 0);

    // both banks full: writer stalls, held write is not taken
    fill(3, 64, 0);
    chk("b0_wr_bank", o_wr_bank, 1);
    fill(4, 64, 1);
    chk("both_wr_ready", o_wr_ready, 0);
    i_wr_valid = 1'b1; i_wr_nbin = mk_nbin(5, 0); i_wr_offset = mk_off(5, 0);
    step(); step();
    chk("stall_wr_bank", o_wr_bank, 0);
    chk("stall_wr_ready", o_wr_ready, 0);
    // read entry 5 and release bank0 on the same edge while the write is still held
    i_rd_en = 1'b1; i_rd_addr = AW'(5); i_rd_release = 1'b1;
    step();
    i_rd_en = 1'b0; i_rd_release = 1'b0; i_wr_valid = 1'b0;
    chk("rr_valid", o_rd_valid, 1);
    chk("rr_nbin", o_rd_nbin, mk_nbin(3, 5));
    chk("rr_off", o_rd_offset, mk_off(3, 5));
    chk("rr_wr_ready", o_wr_ready, 1);
    chk("rr_rd_bank", o_rd_bank, 1);
    chk("rr_avail", o_rd_avail, 1);
    chk("rr_count", o_rd_count, 64);
    rd_chk("b1_rd63", 63, 4, 0);

    // last write on bank0 coincides with release of bank1
    fill(6, 19, 0);
    i_wr_valid = 1'b1; i_wr_nbin = mk_nbin(6, 19); i_wr_offset = mk_off(6, 19); i_wr_last = 1'b1;
    i_rd_release = 1'b1;
    step();
    i_wr_valid = 1'b0; i_wr_last = 1'b0; i_rd_release = 1'b0;
    chk("sim_rd_bank", o_rd_bank, 0);
    chk("sim_avail", o_rd_avail, 1);
    chk("sim_wr_bank", o_wr_bank, 1);
    chk("sim_wr_ready", o_wr_ready, 1);
    chk("sim_count", o_rd_count, 20);
    rd_chk("sim_rd0", 0, 6, 0);
    rd_chk("sim_rd19", 19, 6, 0);

    // reset mid-fill (wr_ptr=30) and mid-read
    fill(7, 30, 0);
    chk("mid_wr_bank", o_wr_bank, 1);
    i_rd_en = 1'b1; i_rd_addr = AW'(3);
    step();
    i_rd_en = 1'b0;
    chk("mid_rd_valid", o_rd_valid, 1);
    chk("mid_rd_nbin", o_rd_nbin, mk_nbin(6, 3));
    rst_n = 1'b0;
    #1;
    chk_reset_outs("midrst");
    step();
    rst_n = 1'b1;
    step();
    fill(8, 5, 1);
    chk("post_wr_bank", o_wr_bank, 1);
    chk("post_rd_bank", o_rd_bank, 0);
    chk("post_count", o_rd_count, 5);
    rd_chk("post_rd0", 0, 8, 0);
    rd_chk("post_rd4", 4, 8, 0);
    rd_chk("post_rd5", 5, 8, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
